// File: rtl/alu_busy_tracker.sv
// Issue-side occupancy tracker for the SIMD, SIMF, SALU and LSU execution units.
// Each ALU-style unit is free when its down-counter reaches zero. The LSU is
// tracked as an in-flight count that is bounded by LSU_MAX_OUTSTANDING. Any
// illegal issue or retire sets a sticky protocol error flag.
module alu_busy_tracker #(
  parameter int SIMD_BUSY_CYCLES    = 4,
  parameter int SIMF_BUSY_CYCLES    = 4,
  parameter int SALU_BUSY_CYCLES    = 1,
  parameter int LSU_MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_simd0_alu_select,
  input  logic       c_simd1_alu_select,
  input  logic       c_simd2_alu_select,
  input  logic       c_simd3_alu_select,
  input  logic       c_simf0_alu_select,
  input  logic       c_simf1_alu_select,
  input  logic       c_simf2_alu_select,
  input  logic       c_simf3_alu_select,
  input  logic       c_lsu_lsu_select,
  input  logic       c_salu_alu_select,
  input  logic       lsu_done,
  output logic       f_simd0_alu_ready,
  output logic       f_simd1_alu_ready,
  output logic       f_simd2_alu_ready,
  output logic       f_simd3_alu_ready,
  output logic       f_simf0_alu_ready,
  output logic       f_simf1_alu_ready,
  output logic       f_simf2_alu_ready,
  output logic       f_simf3_alu_ready,
  output logic       f_lsu_ready,
  output logic       f_salu_alu_ready,
  output logic [2:0] lsu_outstanding,
  output logic       protocol_err
);

  localparam logic [2:0] SIMD_BUSY = 3'(SIMD_BUSY_CYCLES);
  localparam logic [2:0] SIMF_BUSY = 3'(SIMF_BUSY_CYCLES);
  localparam logic [2:0] SALU_BUSY = 3'(SALU_BUSY_CYCLES);
  localparam logic [2:0] LSU_MAX   = 3'(LSU_MAX_OUTSTANDING);

  logic [2:0] simd_cnt [4];
  logic [2:0] simf_cnt [4];
  logic [2:0] salu_cnt;
  logic [2:0] lsu_cnt;
  logic       err_q;

  logic [3:0] simd_sel;
  logic [3:0] simf_sel;
  logic [3:0] simd_rdy;
  logic [3:0] simf_rdy;
  logic       salu_rdy;

  logic [2:0] lsu_cnt_nxt;
  logic       lsu_err;
  logic       busy_err;
  logic       group_err;

  // Next value of a busy down-counter: reload on an accepted select, else count down to zero.
  function automatic logic [2:0] busy_next(input logic [2:0] cnt, input logic sel,
                                           input logic [2:0] busy);
    logic [2:0] nxt;
    nxt = cnt;
    if (sel && (cnt == 3'd0)) nxt = busy;
    else if (cnt != 3'd0)     nxt = cnt - 3'd1;
    return nxt;
  endfunction

  // True when more than one bit of the group select vector is set.
  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  assign simd_sel = {c_simd3_alu_select, c_simd2_alu_select,
                     c_simd1_alu_select, c_simd0_alu_select};
  assign simf_sel = {c_simf3_alu_select, c_simf2_alu_select,
                     c_simf1_alu_select, c_simf0_alu_select};

  // Ready decode straight from the counter registers.
  always_comb begin
    simd_rdy = 4'b0000;
    simf_rdy = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      simd_rdy[i] = (simd_cnt[i] == 3'd0);
      simf_rdy[i] = (simf_cnt[i] == 3'd0);
    end
    salu_rdy = (salu_cnt == 3'd0);
  end

  // LSU in-flight count update; simultaneous issue and retire cancel out.
  always_comb begin
    lsu_cnt_nxt = lsu_cnt;
    lsu_err     = 1'b0;
    if (c_lsu_lsu_select && !lsu_done) begin
      if (lsu_cnt >= LSU_MAX) lsu_err = 1'b1;
      else                    lsu_cnt_nxt = lsu_cnt + 3'd1;
    end else if (lsu_done && !c_lsu_lsu_select) begin
      if (lsu_cnt == 3'd0) lsu_err = 1'b1;
      else                 lsu_cnt_nxt = lsu_cnt - 3'd1;
    end
  end

  // Protocol violations: selecting a busy unit, or multiple selects within a group.
  always_comb begin
    busy_err  = (|(simd_sel & ~simd_rdy)) | (|(simf_sel & ~simf_rdy)) |
                (c_salu_alu_select & ~salu_rdy);
    group_err = multi_hot(simd_sel) | multi_hot(simf_sel);
  end

  // State registers; reset abandons all busy periods and in-flight LSU work.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        simd_cnt[i] <= 3'd0;
        simf_cnt[i] <= 3'd0;
      end
      salu_cnt <= 3'd0;
      lsu_cnt  <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        simd_cnt[i] <= busy_next(simd_cnt[i], simd_sel[i], SIMD_BUSY);
        simf_cnt[i] <= busy_next(simf_cnt[i], simf_sel[i], SIMF_BUSY);
      end
      salu_cnt <= busy_next(salu_cnt, c_salu_alu_select, SALU_BUSY);
      lsu_cnt  <= lsu_cnt_nxt;
      err_q    <= err_q | busy_err | group_err | lsu_err;
    end
  end

  assign f_simd0_alu_ready = simd_rdy[0];
  assign f_simd1_alu_ready = simd_rdy[1];
  assign f_simd2_alu_ready = simd_rdy[2];
  assign f_simd3_alu_ready = simd_rdy[3];
  assign f_simf0_alu_ready = simf_rdy[0];
  assign f_simf1_alu_ready = simf_rdy[1];
  assign f_simf2_alu_ready = simf_rdy[2];
  assign f_simf3_alu_ready = simf_rdy[3];
  assign f_salu_alu_ready  = salu_rdy;
  assign f_lsu_ready       = (lsu_cnt < LSU_MAX);
  assign lsu_outstanding   = lsu_cnt;
  assign protocol_err      = err_q;

endmodule

// File: tb/tb_alu_busy_tracker.sv
// Scoreboard bench for alu_busy_tracker with default parameters. Each stimulus
// step pushes the hand-computed outputs expected after its clock edge; a
// monitor pops one entry per edge and compares against the DUT.
module tb_alu_busy_tracker;

  typedef struct packed {
    logic [3:0] simd;
    logic [3:0] simf;
    logic       salu;
    logic       lsu_rdy;
    logic [2:0] lsu_out;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] simd_sel = 4'b0;
  logic [3:0] simf_sel = 4'b0;
  logic       salu_sel = 1'b0;
  logic       lsu_sel = 1'b0;
  logic       lsu_done = 1'b0;

  logic       f_simd0, f_simd1, f_simd2, f_simd3;
  logic       f_simf0, f_simf1, f_simf2, f_simf3;
  logic       f_lsu_ready, f_salu_ready, protocol_err;
  logic [2:0] lsu_outstanding;

  exp_t  sb [$];
  string tags [$];
  int    vectors = 0;
  int    miscompares = 0;
  exp_t  exp_v;
  exp_t  act_v;
  string tag_v;

  alu_busy_tracker dut (
    .clk                (clk),
    .rst                (rst),
    .c_simd0_alu_select (simd_sel[0]),
    .c_simd1_alu_select (simd_sel[1]),
    .c_simd2_alu_select (simd_sel[2]),
    .c_simd3_alu_select (simd_sel[3]),
    .c_simf0_alu_select (simf_sel[0]),
    .c_simf1_alu_select (simf_sel[1]),
    .c_simf2_alu_select (simf_sel[2]),
    .c_simf3_alu_select (simf_sel[3]),
    .c_lsu_lsu_select   (lsu_sel),
    .c_salu_alu_select  (salu_sel),
    .lsu_done           (lsu_done),
    .f_simd0_alu_ready  (f_simd0),
    .f_simd1_alu_ready  (f_simd1),
    .f_simd2_alu_ready  (f_simd2),
    .f_simd3_alu_ready  (f_simd3),
    .f_simf0_alu_ready  (f_simf0),
    .f_simf1_alu_ready  (f_simf1),
    .f_simf2_alu_ready  (f_simf2),
    .f_simf3_alu_ready  (f_simf3),
    .f_lsu_ready        (f_lsu_ready),
    .f_salu_alu_ready   (f_salu_ready),
    .lsu_outstanding    (lsu_outstanding),
    .protocol_err       (protocol_err)
  );

  always #5 clk = ~clk;

  // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      tag_v = tags.pop_front();
      act_v = '{simd: {f_simd3, f_simd2, f_simd1, f_simd0},
                simf: {f_simf3, f_simf2, f_simf1, f_simf0},
                salu: f_salu_ready, lsu_rdy: f_lsu_ready,
                lsu_out: lsu_outstanding, err: protocol_err};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s: got simd=%b simf=%b salu=%b lsu_rdy=%b lsu_out=%0d err=%b, want simd=%b simf=%b salu=%b lsu_rdy=%b lsu_out=%0d err=%b",
                 tag_v, act_v.simd, act_v.simf, act_v.salu, act_v.lsu_rdy, act_v.lsu_out, act_v.err,
                 exp_v.simd, exp_v.simf, exp_v.salu, exp_v.lsu_rdy, exp_v.lsu_out, exp_v.err);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input string tag, input logic rn,
                      input logic [3:0] sd, input logic [3:0] sf, input logic sa,
                      input logic ls, input logic dn,
                      input logic [3:0] e_sd, input logic [3:0] e_sf, input logic e_sa,
                      input logic e_lr, input logic [2:0] e_lo, input logic e_er);
    @(negedge clk);
    rst      = rn;
    simd_sel = sd;
    simf_sel = sf;
    salu_sel = sa;
    lsu_sel  = ls;
    lsu_done = dn;
    sb.push_back('{simd: e_sd, simf: e_sf, salu: e_sa, lsu_rdy: e_lr, lsu_out: e_lo, err: e_er});
    tags.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [3:0] e_sd, input logic [3:0] e_sf,
                      input logic e_sa, input logic e_lr, input logic [2:0] e_lo,
                      input logic e_er);
    step(tag, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, e_sd, e_sf, e_sa, e_lr, e_lo, e_er);
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);
  endtask

  initial begin
    // Reset overrides simultaneous selects and multi-select errors.
    step("rst_override", 1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);
    idle("post_rst", 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);

    // SIMD2 busy four cycles, others unaffected.
    step("simd2_sel", 1'b1, 4'b0100, 4'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) idle("simd2_busy", 4'b1011, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);
    idle("simd2_free", 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);

    // SALU busy exactly one cycle.
    step("salu_sel", 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 3'd0, 1'b0);
    idle("salu_free", 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);

    // Independent units selected together: no error.
    step("mixed_sel", 1'b1, 4'b1000, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0111, 4'b1011, 1'b0, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) idle("mixed_busy", 4'b0111, 4'b1011, 1'b1, 1'b1, 3'd0, 1'b0);
    idle("mixed_free", 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);

    // Select and done together at zero count: unchanged, no error.
    step("lsu_both_at0", 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);

    // Fill LSU to the limit, then overflow.
    step("lsu_fill1", 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 3'd1, 1'b0);
    step("lsu_fill2", 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 3'd2, 1'b0);
    step("lsu_fill3", 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 3'd3, 1'b0);
    step("lsu_fill4", 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 3'd4, 1'b0);
    step("lsu_overflow", 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 3'd4, 1'b1);
    idle("err_sticky", 4'hF, 4'hF, 1'b1, 1'b0, 3'd4, 1'b1);
    do_reset("rst_after_ovf");

    // Full LSU with simultaneous select and done, then drain and underflow.
    for (int i = 1; i <= 4; i++)
      step("lsu_refill", 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, (i < 4), 3'(i), 1'b0);
    step("lsu_both_full", 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 3'd4, 1'b0);
    for (int i = 3; i >= 0; i--)
      step("lsu_drain", 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 3'(i), 1'b0);
    step("lsu_underflow", 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b1);
    do_reset("rst_after_unf");

    // Reselect of busy SIMF0 is ignored and flagged.
    step("simf0_sel", 1'b1, 4'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'hF, 4'b1110, 1'b1, 1'b1, 3'd0, 1'b0);
    idle("simf0_busy", 4'hF, 4'b1110, 1'b1, 1'b1, 3'd0, 1'b0);
    step("simf0_resel", 1'b1, 4'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'hF, 4'b1110, 1'b1, 1'b1, 3'd0, 1'b1);
    idle("simf0_busy2", 4'hF, 4'b1110, 1'b1, 1'b1, 3'd0, 1'b1);
    idle("simf0_free", 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b1);
    do_reset("rst_after_resel");

    // Two SIMD selects together: both accepted, error flagged.
    step("simd01_sel", 1'b1, 4'b0011, 4'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 4'hF, 1'b1, 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) idle("simd01_busy", 4'b1100, 4'hF, 1'b1, 1'b1, 3'd0, 1'b1);
    idle("simd01_free", 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b1);
    do_reset("rst_after_multi");

    // Mid-operation reset: SALU busy, LSU at 2, error set, SIMD busy.
    step("mid_a", 1'b1, 4'b0011, 4'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 4'hF, 1'b1, 1'b1, 3'd1, 1'b1);
    step("mid_b", 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'hF, 1'b0, 1'b1, 3'd2, 1'b1);
    do_reset("mid_rst");
    idle("mid_post", 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
